// File: rtl/mem_arbiter.sv
// Purpose: shares one memory port between IF and MEM, with round-robin arbitration and one transaction outstanding.
// Latency: request seen in IDLE at cycle 0, mem_req_o at cycle 1, response strobe at cycle 3 at the earliest.
// Backpressure: a requester holds req until its valid strobe; mem_req_o is held until mem_gnt_i, and a timeout ends the wait.
//
// Ports:
//   clk, resetn_i                        clock and asynchronous active-low reset
//   IF_ARB_*  / ARB_IF_*                 fetch request (read only) and its response (valid, rdata, err)
//   MEM_ARB_* / ARB_MEM_*                load/store request and its response (valid, rdata, err)
//   mem_req_o, mem_we/addr/wdata/be_o    latched command to the memory wrapper
//   mem_gnt_i, mem_rvalid_i, mem_rdata_i memory acceptance and response
module mem_arbiter #(
    parameter int BITSIZE = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                   clk,
    input  logic                   resetn_i,
    input  logic                   IF_ARB_req_i,
    input  logic [BITSIZE-1:0]     IF_ARB_addr_i,
    output logic                   ARB_IF_valid_o,
    output logic [BITSIZE-1:0]     ARB_IF_rdata_o,
    output logic                   ARB_IF_err_o,
    input  logic                   MEM_ARB_req_i,
    input  logic                   MEM_ARB_we_i,
    input  logic [BITSIZE-1:0]     MEM_ARB_addr_i,
    input  logic [BITSIZE-1:0]     MEM_ARB_wdata_i,
    input  logic [BITSIZE/8-1:0]   MEM_ARB_be_i,
    output logic                   ARB_MEM_valid_o,
    output logic [BITSIZE-1:0]     ARB_MEM_rdata_o,
    output logic                   ARB_MEM_err_o,
    output logic                   mem_req_o,
    output logic                   mem_we_o,
    output logic [BITSIZE-1:0]     mem_addr_o,
    output logic [BITSIZE-1:0]     mem_wdata_o,
    output logic [BITSIZE/8-1:0]   mem_be_o,
    input  logic                   mem_gnt_i,
    input  logic                   mem_rvalid_i,
    input  logic [BITSIZE-1:0]     mem_rdata_i
);

    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2, RESP = 2'd3} state_t;

    localparam logic [15:0] TMO = 16'(TIMEOUT);

    state_t               state_q, state_d;
    logic                 owner_q, owner_d;   // 1 = MEM owns the transaction
    logic                 last_q,  last_d;    // 1 = MEM was granted last
    logic [15:0]          cnt_q,   cnt_d;
    logic                 err_q,   err_d;
    logic [BITSIZE-1:0]   rdata_q, rdata_d;
    logic                 we_q,    we_d;
    logic [BITSIZE-1:0]   addr_q,  addr_d;
    logic [BITSIZE-1:0]   wdata_q, wdata_d;
    logic [BITSIZE/8-1:0] be_q,    be_d;
    logic                 grant_mem;
    logic                 resp_if, resp_mem;

    always_ff @(posedge clk or negedge resetn_i) begin
        if (!resetn_i) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        rdata_d   = rdata_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        be_d      = be_q;
        grant_mem = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (IF_ARB_req_i || MEM_ARB_req_i) begin
                    // Under contention the stage not granted last wins.
                    grant_mem = MEM_ARB_req_i && (!IF_ARB_req_i || !last_q);
                    owner_d   = grant_mem;
                    last_d    = grant_mem;
                    cnt_d     = '0;
                    state_d   = REQ;
                    if (grant_mem) begin
                        we_d    = MEM_ARB_we_i;
                        addr_d  = MEM_ARB_addr_i;
                        wdata_d = MEM_ARB_wdata_i;
                        be_d    = MEM_ARB_be_i;
                    end else begin
                        we_d    = 1'b0;
                        addr_d  = IF_ARB_addr_i;
                        wdata_d = '0;
                        be_d    = '1;
                    end
                end
            end
            REQ: begin
                cnt_d = cnt_q + 16'd1;
                if (cnt_q >= TMO) begin
                    state_d = RESP;
                    err_d   = 1'b1;
                    rdata_d = '0;
                end else if (mem_gnt_i) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q + 16'd1;
                // A response arriving on the timeout cycle still counts as a response.
                if (mem_rvalid_i) begin
                    state_d = RESP;
                    err_d   = 1'b0;
                    rdata_d = we_q ? '0 : mem_rdata_i;
                end else if (cnt_q >= TMO) begin
                    state_d = RESP;
                    err_d   = 1'b1;
                    rdata_d = '0;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        resp_if         = (state_q == RESP) && !owner_q;
        resp_mem        = (state_q == RESP) &&  owner_q;
        mem_req_o       = (state_q == REQ);
        mem_we_o        = we_q;
        mem_addr_o      = addr_q;
        mem_wdata_o     = wdata_q;
        mem_be_o        = be_q;
        ARB_IF_valid_o  = resp_if;
        ARB_IF_rdata_o  = resp_if ? rdata_q : '0;
        ARB_IF_err_o    = resp_if && err_q;
        ARB_MEM_valid_o = resp_mem;
        ARB_MEM_rdata_o = resp_mem ? rdata_q : '0;
        ARB_MEM_err_o   = resp_mem && err_q;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Purpose: directed scoreboard bench for mem_arbiter with a scriptable memory responder.
// Latency: expected responses carry the exact cycle on which the valid strobe must appear.
// Backpressure: the responder delays gnt/rvalid per test, or withholds rvalid to force a timeout.
module tb_mem_arbiter;

    logic        clk;
    logic        resetn_i;
    logic        IF_ARB_req_i;
    logic [31:0] IF_ARB_addr_i;
    logic        ARB_IF_valid_o;
    logic [31:0] ARB_IF_rdata_o;
    logic        ARB_IF_err_o;
    logic        MEM_ARB_req_i;
    logic        MEM_ARB_we_i;
    logic [31:0] MEM_ARB_addr_i;
    logic [31:0] MEM_ARB_wdata_i;
    logic [3:0]  MEM_ARB_be_i;
    logic        ARB_MEM_valid_o;
    logic [31:0] ARB_MEM_rdata_o;
    logic        ARB_MEM_err_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [3:0]  mem_be_o;
    logic        mem_gnt_i;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;

    mem_arbiter #(.BITSIZE(32), .TIMEOUT(8)) dut (
        .clk             (clk),
        .resetn_i        (resetn_i),
        .IF_ARB_req_i    (IF_ARB_req_i),
        .IF_ARB_addr_i   (IF_ARB_addr_i),
        .ARB_IF_valid_o  (ARB_IF_valid_o),
        .ARB_IF_rdata_o  (ARB_IF_rdata_o),
        .ARB_IF_err_o    (ARB_IF_err_o),
        .MEM_ARB_req_i   (MEM_ARB_req_i),
        .MEM_ARB_we_i    (MEM_ARB_we_i),
        .MEM_ARB_addr_i  (MEM_ARB_addr_i),
        .MEM_ARB_wdata_i (MEM_ARB_wdata_i),
        .MEM_ARB_be_i    (MEM_ARB_be_i),
        .ARB_MEM_valid_o (ARB_MEM_valid_o),
        .ARB_MEM_rdata_o (ARB_MEM_rdata_o),
        .ARB_MEM_err_o   (ARB_MEM_err_o),
        .mem_req_o       (mem_req_o),
        .mem_we_o        (mem_we_o),
        .mem_addr_o      (mem_addr_o),
        .mem_wdata_o     (mem_wdata_o),
        .mem_be_o        (mem_be_o),
        .mem_gnt_i       (mem_gnt_i),
        .mem_rvalid_i    (mem_rvalid_i),
        .mem_rdata_i     (mem_rdata_i)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t q_if[$];
    exp_t q_mem[$];
    exp_t e_if;
    exp_t e_mem;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int pushed_if = 0;
    int pushed_mem = 0;
    int n_if = 0;
    int n_mem = 0;
    int gnt_dly = 0;
    int rv_dly = 1;
    int mode = 0;          // 1 = never answer in time, send a late rvalid instead
    int req_run = 0;
    int last_req_len = 0;
    int cmd_unstable = 0;
    logic [68:0] cmd_prev;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic at_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic push_if(input logic [31:0] d, input logic e, input int c);
        exp_t x;
        x.rdata = d;
        x.err   = e;
        x.cyc   = c;
        q_if.push_back(x);
        pushed_if++;
    endtask

    task automatic push_mem(input logic [31:0] d, input logic e, input int c);
        exp_t x;
        x.rdata = d;
        x.err   = e;
        x.cyc   = c;
        q_mem.push_back(x);
        pushed_mem++;
    endtask

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return (a == 32'h100) ? 32'hDEADBEEF : (a ^ 32'hCAFE0000);
    endfunction

    // Memory responder: gnt after gnt_dly cycles in REQ, rvalid rv_dly cycles after gnt.
    initial begin
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = '0;
        forever begin
            @(negedge clk);
            if (mem_req_o) begin
                logic [31:0] a;
                a = mem_addr_o;
                repeat (gnt_dly) @(negedge clk);
                mem_gnt_i = 1'b1;
                @(negedge clk);
                mem_gnt_i = 1'b0;
                if (mode == 1) repeat (10) @(negedge clk);
                else repeat (rv_dly - 1) @(negedge clk);
                mem_rvalid_i = 1'b1;
                mem_rdata_i  = word_at(a);
                @(negedge clk);
                mem_rvalid_i = 1'b0;
                mem_rdata_i  = '0;
            end
        end
    end

    // Request-length and command-stability tracker.
    always @(negedge clk) begin
        if (mem_req_o) begin
            if (req_run > 0 && {mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o} != cmd_prev)
                cmd_unstable++;
            req_run++;
            cmd_prev = {mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o};
        end else if (req_run > 0) begin
            last_req_len = req_run;
            req_run = 0;
        end
    end

    // Response monitor: pops the per-port queue on every valid strobe.
    always @(negedge clk) begin
        if (ARB_IF_valid_o === 1'b1) begin
            n_if++;
            if (q_if.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL if_unexpected_valid: got valid with rdata %0h err %0b, required none", ARB_IF_rdata_o, ARB_IF_err_o);
            end else begin
                e_if = q_if.pop_front();
                chk("if_cycle", 32'(cyc), 32'(e_if.cyc));
                chk("if_rdata", ARB_IF_rdata_o, e_if.rdata);
                chk("if_err", 32'(ARB_IF_err_o), 32'(e_if.err));
                chk("mem_quiet_on_if", 32'({ARB_MEM_valid_o, ARB_MEM_err_o, |ARB_MEM_rdata_o}), 32'd0);
            end
        end
        if (ARB_MEM_valid_o === 1'b1) begin
            n_mem++;
            if (q_mem.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL mem_unexpected_valid: got valid with rdata %0h err %0b, required none", ARB_MEM_rdata_o, ARB_MEM_err_o);
            end else begin
                e_mem = q_mem.pop_front();
                chk("mem_cycle", 32'(cyc), 32'(e_mem.cyc));
                chk("mem_rdata", ARB_MEM_rdata_o, e_mem.rdata);
                chk("mem_err", 32'(ARB_MEM_err_o), 32'(e_mem.err));
                chk("if_quiet_on_mem", 32'({ARB_IF_valid_o, ARB_IF_err_o, |ARB_IF_rdata_o}), 32'd0);
            end
        end
    end

    initial begin
        int t0;
        resetn_i        = 1'b0;
        IF_ARB_req_i    = 1'b0;
        IF_ARB_addr_i   = '0;
        MEM_ARB_req_i   = 1'b0;
        MEM_ARB_we_i    = 1'b0;
        MEM_ARB_addr_i  = '0;
        MEM_ARB_wdata_i = '0;
        MEM_ARB_be_i    = '0;

        // Reset state
        at_cyc(2);
        chk("rst_mem_req", 32'(mem_req_o), 32'd0);
        chk("rst_mem_addr", mem_addr_o, 32'd0);
        chk("rst_valids", 32'({ARB_IF_valid_o, ARB_MEM_valid_o}), 32'd0);
        resetn_i = 1'b1;

        // Contention from reset: MEM store first, then alternating
        t0 = 4;
        at_cyc(t0);
        IF_ARB_req_i    = 1'b1;
        IF_ARB_addr_i   = 32'h300;
        MEM_ARB_req_i   = 1'b1;
        MEM_ARB_we_i    = 1'b1;
        MEM_ARB_addr_i  = 32'h200;
        MEM_ARB_wdata_i = 32'h12345678;
        MEM_ARB_be_i    = 4'hF;
        push_mem(32'h0, 1'b0, t0 + 3);
        push_if(32'hCAFE0300, 1'b0, t0 + 7);
        push_mem(32'hCAFE0204, 1'b0, t0 + 11);
        push_if(32'hCAFE0304, 1'b0, t0 + 15);
        at_cyc(t0 + 1);
        chk("cont_mem_req", 32'(mem_req_o), 32'd1);
        chk("cont_mem_we", 32'(mem_we_o), 32'd1);
        chk("cont_mem_addr", mem_addr_o, 32'h200);
        chk("cont_mem_wdata", mem_wdata_o, 32'h12345678);
        chk("cont_mem_be", 32'(mem_be_o), 32'hF);
        at_cyc(t0 + 3);
        MEM_ARB_we_i    = 1'b0;
        MEM_ARB_addr_i  = 32'h204;
        MEM_ARB_wdata_i = 32'h0;
        at_cyc(t0 + 5);
        chk("cont_second_addr", mem_addr_o, 32'h300);
        chk("cont_second_we", 32'(mem_we_o), 32'd0);
        at_cyc(t0 + 7);
        IF_ARB_addr_i = 32'h304;
        at_cyc(t0 + 9);
        chk("cont_third_addr", mem_addr_o, 32'h204);
        at_cyc(t0 + 11);
        MEM_ARB_req_i = 1'b0;
        at_cyc(t0 + 15);
        IF_ARB_req_i = 1'b0;

        // IF only, minimum latency
        t0 = 21;
        at_cyc(t0);
        IF_ARB_req_i  = 1'b1;
        IF_ARB_addr_i = 32'h100;
        push_if(32'hDEADBEEF, 1'b0, t0 + 3);
        at_cyc(t0 + 3);
        IF_ARB_req_i = 1'b0;
        at_cyc(t0 + 5);
        chk("min_req_len", 32'(last_req_len), 32'd1);

        // gnt delayed 3 cycles, rvalid 5 cycles after gnt
        t0 = 28;
        at_cyc(t0);
        gnt_dly       = 3;
        rv_dly        = 5;
        IF_ARB_req_i  = 1'b1;
        IF_ARB_addr_i = 32'h500;
        push_if(32'hCAFE0500, 1'b0, t0 + 10);
        at_cyc(t0 + 2);
        chk("dly_req_held", 32'(mem_req_o), 32'd1);
        at_cyc(t0 + 10);
        IF_ARB_req_i = 1'b0;
        at_cyc(t0 + 12);
        chk("dly_req_len", 32'(last_req_len), 32'd4);
        gnt_dly = 0;
        rv_dly  = 1;

        // Timeout: no response in time, late rvalid afterwards
        t0 = 43;
        at_cyc(t0);
        mode          = 1;
        IF_ARB_req_i  = 1'b1;
        IF_ARB_addr_i = 32'h800;
        push_if(32'h0, 1'b1, t0 + 10);
        at_cyc(t0 + 10);
        IF_ARB_req_i = 1'b0;
        at_cyc(t0 + 16);
        mode = 0;

        // MEM holds req for three back-to-back loads
        t0 = 61;
        at_cyc(t0);
        MEM_ARB_req_i   = 1'b1;
        MEM_ARB_we_i    = 1'b0;
        MEM_ARB_addr_i  = 32'h400;
        MEM_ARB_be_i    = 4'hF;
        push_mem(32'hCAFE0400, 1'b0, t0 + 3);
        push_mem(32'hCAFE0404, 1'b0, t0 + 7);
        push_mem(32'hCAFE0408, 1'b0, t0 + 11);
        at_cyc(t0 + 3);
        MEM_ARB_addr_i = 32'h404;
        at_cyc(t0 + 7);
        MEM_ARB_addr_i = 32'h408;
        at_cyc(t0 + 11);
        MEM_ARB_req_i = 1'b0;

        // Asynchronous reset during WAIT, stale rvalid, then a clean request
        t0 = 75;
        at_cyc(t0);
        mode          = 1;
        IF_ARB_req_i  = 1'b1;
        IF_ARB_addr_i = 32'h600;
        at_cyc(t0 + 3);
        chk("pre_rst_addr", mem_addr_o, 32'h600);
        chk("pre_rst_req", 32'(mem_req_o), 32'd0);
        IF_ARB_req_i = 1'b0;
        #2;
        resetn_i = 1'b0;
        #1;
        chk("arst_mem_addr", mem_addr_o, 32'd0);
        chk("arst_mem_be", 32'(mem_be_o), 32'd0);
        chk("arst_valids", 32'({ARB_IF_valid_o, ARB_MEM_valid_o, mem_req_o}), 32'd0);
        at_cyc(t0 + 5);
        resetn_i = 1'b1;
        at_cyc(t0 + 14);
        mode          = 0;
        IF_ARB_req_i  = 1'b1;
        IF_ARB_addr_i = 32'h700;
        push_if(32'hCAFE0700, 1'b0, t0 + 17);
        at_cyc(t0 + 17);
        IF_ARB_req_i = 1'b0;

        at_cyc(t0 + 21);
        chk("if_valid_count", 32'(n_if), 32'(pushed_if));
        chk("mem_valid_count", 32'(n_mem), 32'(pushed_mem));
        chk("if_queue_drained", 32'(q_if.size()), 32'd0);
        chk("mem_queue_drained", 32'(q_mem.size()), 32'd0);
        chk("cmd_stable", 32'(cmd_unstable), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the core's single memory port between the instruction-fetch stage (IF) and the memory-access stage (MEM). It accepts one request at a time from either stage over the pipeline's req/valid handshake, drives the memory port, and waits for the response. It returns the read data, or a timeout error, to the requester that owns the transaction. It sits between IF/MEM and the memory wrapper and keeps one transaction outstanding at most.

## Interface
- BITSIZE, 32, data and address width
- TIMEOUT, 255, max cycles from grant to memory response before error; 1..2^16-1
- clk  in  1  clock, rising edge
- resetn_i  in  1  asynchronous active-low reset
- IF_ARB_req_i  in  1  IF request; held until ARB_IF_valid_o
- IF_ARB_addr_i  in  BITSIZE  IF fetch address (read only)
- ARB_IF_valid_o  out  1  one-cycle response strobe to IF
- ARB_IF_rdata_o  out  BITSIZE  fetched word
- ARB_IF_err_o  out  1  timeout error, qualified by valid
- MEM_ARB_req_i  in  1  MEM request; held until ARB_MEM_valid_o
- MEM_ARB_we_i  in  1  1 = store, 0 = load
- MEM_ARB_addr_i  in  BITSIZE  data address
- MEM_ARB_wdata_i  in  BITSIZE  store data
- MEM_ARB_be_i  in  BITSIZE/8  byte enables
- ARB_MEM_valid_o  out  1  one-cycle response strobe to MEM
- ARB_MEM_rdata_o  out  BITSIZE  load data (0 for stores)
- ARB_MEM_err_o  out  1  timeout error, qualified by valid
- mem_req_o  out  1  request to memory; held until mem_gnt_i
- mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o  out  1/BITSIZE/BITSIZE/BITSIZE/8  latched command
- mem_gnt_i  in  1  memory accepted command
- mem_rvalid_i  in  1  memory response strobe
- mem_rdata_i  in  BITSIZE  memory read data

## Operation
- FSM states: IDLE, REQ, WAIT, RESP. Reset state is IDLE.
- IDLE: if any req_i is high, pick a winner, latch its command into the mem_* registers, and record the owner. The FSM goes to REQ.
- Arbitration is round-robin. On a simultaneous request, grant the stage that was not granted last. The last-grant register resets to IF, so MEM wins the first contention. A lone requester is always granted.
- REQ: mem_req_o=1 and the command is held stable. On mem_gnt_i, go to WAIT.
- WAIT: mem_req_o=0. On mem_rvalid_i, latch mem_rdata_i and go to RESP with err=0. mem_rvalid_i is ignored in every other state.
- Timeout counter: cleared on entry to REQ and increments each cycle in REQ and WAIT. If it reaches TIMEOUT without a response, go to RESP with err=1 and rdata=0, and drop mem_req_o. Any late rvalid is ignored.
- RESP: for one cycle, the owner's valid_o=1 with its rdata_o and err_o. The non-owner's outputs stay 0. Next state is IDLE.
- Store responses return rdata=0.
- Requester rule: req and command stay stable from assertion through the valid cycle. If req is still high in the cycle after valid, it is a new request.
- Requester inputs are not sampled outside IDLE; changes made while another stage owns the port have no effect.

## Timing
- Reset (async assert) sets all outputs to 0, state to IDLE, counter to 0, and last-grant to IF. An in-flight transaction is discarded with no response. Deassertion is synchronous to clk through the team reset synchronizer.
- Minimum latency: req seen in IDLE at cycle 0. mem_req_o is high at cycle 1 with gnt the same cycle. rvalid arrives at cycle 2. valid_o is high at cycle 3.
- Every added gnt or rvalid wait cycle adds one cycle of latency.
- Back-to-back: the earliest next grant is the IDLE cycle after RESP, so the port turnaround is 4 cycles minimum.
- With continuous contention, grants alternate IF, MEM, IF, and neither requester waits more than one foreign transaction.
- gnt and rvalid in the same cycle: rvalid is not accepted in REQ, so the memory side must not return rvalid before the cycle after gnt.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- IF only, addr 0x100, gnt immediate, rvalid one cycle later with 0xDEADBEEF -> ARB_IF_valid_o high at cycle 3 with rdata 0xDEADBEEF and err 0; the MEM outputs stay 0.
- IF and MEM requesting in the same cycle after reset, with MEM a store of 0x12345678 to 0x200, be 0xF -> MEM is granted first with mem_we_o=1 and the latched address and data; IF is granted next, and the order alternates over 4 contended transactions.
- gnt delayed 3 cycles and rvalid delayed 5 cycles -> mem_req_o is held high for exactly 4 cycles with a stable command, and valid arrives 10 cycles after req.
- TIMEOUT=8, memory never responds -> valid at cycle 10 (grant cycle + 8 + RESP) with err=1 and rdata 0; a late rvalid then produces no second valid.
- resetn_i asserted asynchronously in WAIT -> outputs go to 0 immediately; after release, a stale rvalid is ignored and a new IF request completes normally.
- MEM holds req high continuously, issuing 3 loads -> 3 valid pulses spaced 4 cycles apart at minimum memory latency.
